// File: rtl/mavg_pkg.sv
// Shared definitions for the moving-average unit.
//   ROUND_TRUNC / ROUND_HALF_UP : values of the ROUND parameter
//   SUM_W(data_w, log2_n)       : width of the running sum, which can hold
//                                 N full-scale samples without overflow
package mavg_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    function automatic int SUM_W(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/mavg_window_buf.sv
// Circular window of the last N = 2**LOG2_N accepted samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush of all entries and the write pointer
//   wr_en      : store wr_data in the slot of the oldest sample
//   wr_data    : sample to store
//   oldest     : sample about to be overwritten (0 while the window fills)
module mavg_window_buf
    import mavg_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int LOG2_N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] oldest
);

    localparam int N = 1 << LOG2_N;

    logic [DATA_W-1:0] win [N];
    logic [LOG2_N-1:0] wr_ptr;

    // The write slot is always the oldest entry, so one pointer serves both
    // the read of the outgoing sample and the write of the incoming one.
    assign oldest = win[wr_ptr];

    // NOTE: the window is a register array with reset, not a RAM: empty slots
    // must read as 0 so the running sum subtracts nothing during the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < N; i++) win[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            for (int i = 0; i < N; i++) win[i] <= '0;
        end else if (wr_en) begin
            win[wr_ptr] <= wr_data;
            // Power-of-two depth: the pointer wraps N-1 -> 0 on its own.
            wr_ptr      <= wr_ptr + LOG2_N'(1);
        end
    end

endmodule

// File: rtl/moving_avg.sv
// Streaming moving average over the last N = 2**LOG2_N accepted samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous window flush (wins over a same-cycle sample)
//   in_valid   : sample offered          in_data  : unsigned sample
//   in_ready   : sample accepted when in_valid & in_ready
//   out_valid  : out_data holds a new average
//   out_data   : unsigned window average, registered one clock after accept
//   out_ready  : consumer takes out_data when out_valid & out_ready
//   out_full   : window has held N samples since reset/clear
module moving_avg
    import mavg_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int LOG2_N = 2,
    parameter int ROUND  = ROUND_TRUNC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_full
);

    localparam int N       = 1 << LOG2_N;
    localparam int SUM_WD  = SUM_W(DATA_W, LOG2_N);
    localparam int COUNT_W = LOG2_N + 1;
    localparam int RND     = (ROUND == ROUND_HALF_UP) ? N / 2 : 0;

    logic [SUM_WD-1:0]  sum, sum_next, rounded;
    logic [COUNT_W-1:0] count, count_next;
    logic [DATA_W-1:0]  oldest, avg;
    logic               accept;

    // Output register frees up when it is empty or being drained this cycle.
    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    mavg_window_buf #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (accept),
        .wr_data (in_data),
        .oldest  (oldest)
    );

    // sum always covers the window contents, so sum >= oldest and the
    // subtraction cannot wrap. Adding the rounding term stays below
    // N * 2**DATA_W, so it also fits SUM_WD bits and the shifted result
    // fits DATA_W bits.
    always_comb begin
        sum_next   = sum + SUM_WD'(in_data) - SUM_WD'(oldest);
        rounded    = sum_next + SUM_WD'(RND);
        avg        = DATA_W'(rounded >> LOG2_N);
        count_next = (count == COUNT_W'(N)) ? count : count + COUNT_W'(1);
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // right-hand side sees values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_full  <= 1'b0;
        end else if (clear) begin
            // A pending output is dropped; out_data keeps its stale value but
            // is never presented as valid.
            sum       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_full  <= 1'b0;
        end else if (accept) begin
            sum       <= sum_next;
            count     <= count_next;
            out_valid <= 1'b1;
            out_data  <= avg;
            out_full  <= (count_next == COUNT_W'(N));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
